select_topk_stream: RTL and testbench

- Parametrised successor to the fixed 24-input/top-6 selector.
- Accepts a stream of N values over a valid/ready handshake and tags each with its arrival index.
- Keeps a sorted top-K list by insertion, one entry per cycle. Mode chooses largest-first or smallest-first.
- After collection, drains the K winners serially as {value, index, group} with valid/ready. Sits between the feature-value generator and the downstream ranking/report stage.

---
 rtl/select_topk_stream.sv | 178 +++++++++++++++++
 tb/tb_select_topk_stream.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/select_topk_stream.sv
// Streaming top-K selector: tags a frame of values with arrival indices, keeps a sorted top-K by insertion,
// then drains the winners in rank order. Define SELECT_TOPK_THRESHOLD_EN to add the Threshold insertion gate.
module select_topk_stream #(
    parameter int unsigned N        = 24,
    parameter int unsigned K        = 6,
    parameter int unsigned VAL_W    = 8,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned GRP_SIZE = 4,
    parameter int unsigned GRP_W    = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Mode,
    input  logic             InValid,
    output logic             InReady,
    input  logic [VAL_W-1:0] InValue,
    input  logic             InLast,
`ifdef SELECT_TOPK_THRESHOLD_EN
    input  logic [VAL_W-1:0] Threshold,
`endif
    output logic             OutValid,
    input  logic             OutReady,
    output logic [VAL_W-1:0] OutValue,
    output logic [IDX_W-1:0] OutIndex,
    output logic [GRP_W-1:0] OutGroup,
    output logic             OutLast,
    output logic             Busy,
    output logic             Done
);
    localparam int unsigned      SECOND   = (K > 1) ? 1 : 0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [VAL_W-1:0] val_q [K];
    logic [VAL_W-1:0] val_d [K];
    logic [IDX_W-1:0] idx_q [K];
    logic [IDX_W-1:0] idx_d [K];
    logic [K-1:0]     vld_q, vld_d;
    logic [K-1:0]     beats;
    logic             candidate;
    logic             done_d;
    logic             out_vld_d;
    logic             out_last_d;
`ifdef SELECT_TOPK_THRESHOLD_EN
    logic [VAL_W-1:0] thr_q, thr_d;
`endif

    // Slots are sorted with invalid ones at the tail, so beats[] is a thermometer code
    always_comb begin
`ifdef SELECT_TOPK_THRESHOLD_EN
        candidate = mode_q ? (InValue <= thr_q) : (InValue >= thr_q);
`else
        candidate = 1'b1;
`endif
        for (int i = 0; i < K; i++) begin
            beats[i] = candidate &&
                       (!vld_q[i] || (mode_q ? (InValue < val_q[i]) : (InValue > val_q[i])));
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        val_d   = val_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
`ifdef SELECT_TOPK_THRESHOLD_EN
        thr_d   = thr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    mode_d  = Mode;
`ifdef SELECT_TOPK_THRESHOLD_EN
                    thr_d   = Threshold;
`endif
                    count_d = '0;
                    vld_d   = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (InValid && InReady) begin
                    if (beats[0]) begin
                        val_d[0] = InValue;
                        idx_d[0] = count_q;
                        vld_d[0] = 1'b1;
                    end
                    // Slots below the insertion point move down one; slot K-1 falls off
                    for (int i = 1; i < K; i++) begin
                        if (beats[i-1]) begin
                            val_d[i] = val_q[i-1];
                            idx_d[i] = idx_q[i-1];
                            vld_d[i] = vld_q[i-1];
                        end else if (beats[i]) begin
                            val_d[i] = InValue;
                            idx_d[i] = count_q;
                            vld_d[i] = 1'b1;
                        end
                    end
                    count_d = count_q + IDX_W'(1);
                    if (InLast || (count_q == LAST_IDX)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!vld_q[0]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (OutValid && OutReady) begin
                    for (int i = 0; i < int'(K) - 1; i++) begin
                        val_d[i] = val_q[i+1];
                        idx_d[i] = idx_q[i+1];
                        vld_d[i] = vld_q[i+1];
                    end
                    vld_d[K-1] = 1'b0;
                    if ((K == 1) || !vld_q[SECOND]) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        out_vld_d  = (state_d == DRAIN) && vld_d[0];
        out_last_d = out_vld_d && ((K == 1) || !vld_d[SECOND]);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            count_q  <= '0;
            vld_q    <= '0;
            for (int i = 0; i < K; i++) begin
                val_q[i] <= '0;
                idx_q[i] <= '0;
            end
`ifdef SELECT_TOPK_THRESHOLD_EN
            thr_q    <= '0;
`endif
            InReady  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
            OutValue <= '0;
            OutIndex <= '0;
            OutGroup <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            val_q    <= val_d;
            idx_q    <= idx_d;
`ifdef SELECT_TOPK_THRESHOLD_EN
            thr_q    <= thr_d;
`endif
            InReady  <= (state_d == COLLECT);
            Busy     <= (state_d != IDLE);
            Done     <= done_d;
            OutValid <= out_vld_d;
            OutLast  <= out_last_d;
            OutValue <= out_vld_d ? val_d[0] : '0;
            OutIndex <= out_vld_d ? idx_d[0] : '0;
            OutGroup <= out_vld_d ? GRP_W'(32'(idx_d[0]) / GRP_SIZE) : '0;
        end
    end
endmodule

// File: tb/tb_select_topk_stream.sv
// Bench for select_topk_stream: table-driven frames, hand-written corner sequences and random frames
// checked against a selection-based reference model.
module tb_select_topk_stream;
    localparam int unsigned N = 24, K = 6, GRP_SIZE = 4;

    typedef struct packed {logic [7:0] v; logic [4:0] i; logic [2:0] g;} ent_t;
    typedef struct {
        bit                  mode;
        bit                  use_last;
        int                  n;
        int                  exp_n;
        logic [0:23][7:0]    data;
        ent_t [0:5]          exp;
    } vec_t;

    logic       Clk = 1'b0, Reset_n = 1'b1, Start = 1'b0, Mode = 1'b0;
    logic       InValid = 1'b0, InLast = 1'b0, OutReady = 1'b0;
    logic [7:0] InValue = '0;
`ifdef SELECT_TOPK_THRESHOLD_EN
    logic [7:0] Threshold = '0;
`endif
    logic       InReady, OutValid, OutLast, Busy, Done;
    logic [7:0] OutValue;
    logic [4:0] OutIndex;
    logic [2:0] OutGroup;

    int   n_checks = 0, n_fail = 0;
    logic [7:0] stim[$];
    ent_t exp_q[$];
    vec_t vec[3];

    select_topk_stream dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode),
        .InValid(InValid), .InReady(InReady), .InValue(InValue), .InLast(InLast),
`ifdef SELECT_TOPK_THRESHOLD_EN
        .Threshold(Threshold),
`endif
        .OutValid(OutValid), .OutReady(OutReady), .OutValue(OutValue), .OutIndex(OutIndex),
        .OutGroup(OutGroup), .OutLast(OutLast), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    function automatic ent_t e(input int v, input int i, input int g);
        ent_t r;
        r.v = 8'(v);
        r.i = 5'(i);
        r.g = 3'(g);
        return r;
    endfunction

    // Reference: repeatedly pick the best remaining eligible entry; strict compare keeps earliest index on ties
    task automatic build_model(input bit mode, input int unsigned thr);
        bit taken [N];
        int best;
        bit ok;
        exp_q.delete();
        for (int j = 0; j < N; j++) taken[j] = 1'b0;
        for (int k = 0; k < K; k++) begin
            best = -1;
            for (int j = 0; j < stim.size(); j++) begin
                ok = mode ? (32'(stim[j]) <= thr) : (32'(stim[j]) >= thr);
                if (ok && !taken[j]) begin
                    if (best < 0) best = j;
                    else if (mode ? (stim[j] < stim[best]) : (stim[j] > stim[best])) best = j;
                end
            end
            if (best >= 0) begin
                taken[best] = 1'b1;
                exp_q.push_back(e(int'(stim[best]), best, best / GRP_SIZE));
            end
        end
    endtask

    // rdy_pct < 0 selects the fixed ready pattern 1,0,0,1
    task automatic run_frame(input bit mode, input int unsigned thr, input bit use_last,
                             input int gap_pct, input int rdy_pct, input bit noise);
        int sent, budget, pos;
        bit fire, rdy, done_seen;
        @(negedge Clk);
        Start = 1'b1;
        Mode  = mode;
`ifdef SELECT_TOPK_THRESHOLD_EN
        Threshold = thr[7:0];
`endif
        @(negedge Clk);
        Start = 1'b0;
        check("busy_after_start", 32'(Busy), 32'd1);
        sent = 0;
        budget = 0;
        while (sent < stim.size() && budget < 2000) begin
            InValid = ($urandom_range(99) >= gap_pct);
            InValue = InValid ? stim[sent] : 8'($urandom);
            InLast  = use_last && (sent == stim.size() - 1);
            if (noise) begin
                Start = 1'($urandom);
                Mode  = 1'($urandom);
`ifdef SELECT_TOPK_THRESHOLD_EN
                Threshold = 8'($urandom);
`endif
            end
            fire = InValid && InReady;
            @(negedge Clk);
            if (fire) sent++;
            budget++;
        end
        InValid = 1'b0;
        InLast  = 1'b0;
        Start   = 1'b0;
        check("collect_count", 32'(sent), 32'(stim.size()));
        check("first_out_valid_latency", 32'(OutValid), 32'(exp_q.size() > 0));
        check("in_ready_drain", 32'(InReady), 32'd0);
        pos = 0;
        budget = 0;
        done_seen = 1'b0;
        while (!done_seen && budget < 300) begin
            if (Done) begin
                done_seen = 1'b1;
            end else begin
                rdy = (rdy_pct < 0) ? ((budget % 4 == 0) || (budget % 4 == 3))
                                    : ($urandom_range(99) < rdy_pct);
                OutReady = rdy;
                if (noise) Start = 1'($urandom);
                if (OutValid) begin
                    if (pos < exp_q.size()) begin
                        check("out_value", 32'(OutValue), 32'(exp_q[pos].v));
                        check("out_index", 32'(OutIndex), 32'(exp_q[pos].i));
                        check("out_group", 32'(OutGroup), 32'(exp_q[pos].g));
                        check("out_last", 32'(OutLast), 32'(pos == exp_q.size() - 1));
                    end else begin
                        check("extra_output", 32'(pos), 32'(exp_q.size()));
                    end
                    if (rdy) pos++;
                end
                @(negedge Clk);
                budget++;
            end
        end
        OutReady = 1'b0;
        Start    = 1'b0;
        check("done_seen", 32'(done_seen), 32'd1);
        check("out_count", 32'(pos), 32'(exp_q.size()));
        @(negedge Clk);
        check("done_one_cycle", 32'(Done), 32'd0);
        check("idle_after_done", 32'(Busy), 32'd0);
    endtask

    task automatic load_vec(input int v);
        stim.delete();
        exp_q.delete();
        for (int j = 0; j < vec[v].n; j++) stim.push_back(vec[v].data[j]);
        for (int j = 0; j < vec[v].exp_n; j++) exp_q.push_back(vec[v].exp[j]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(InReady), 32'd0);
        check({tag, "_out_valid"}, 32'(OutValid), 32'd0);
        check({tag, "_out_last"}, 32'(OutLast), 32'd0);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_done"}, 32'(Done), 32'd0);
        check({tag, "_out_value"}, 32'(OutValue), 32'd0);
        check({tag, "_out_index"}, 32'(OutIndex), 32'd0);
        check({tag, "_out_group"}, 32'(OutGroup), 32'd0);
    endtask

    initial begin
        vec[0].mode = 1'b0; vec[0].use_last = 1'b0; vec[0].n = 24; vec[0].exp_n = 6;
        vec[0].data = {8'd245, 8'd40, 8'd245, 8'd204, 8'd107, 8'd202, 8'd167, 8'd217,
                       8'd173, 8'd190, 8'd167, 8'd180, 8'd70, 8'd24, 8'd177, 8'd243,
                       8'd112, 8'd195, 8'd47, 8'd114, 8'd181, 8'd70, 8'd167, 8'd30};
        vec[0].exp  = {e(245, 0, 0), e(245, 2, 0), e(243, 15, 3),
                       e(217, 7, 1), e(204, 3, 0), e(202, 5, 1)};
        vec[1] = vec[0];
        vec[1].mode = 1'b1;
        vec[1].exp  = {e(24, 13, 3), e(30, 23, 5), e(40, 1, 0),
                       e(47, 18, 4), e(70, 12, 3), e(70, 21, 5)};
        vec[2].mode = 1'b0; vec[2].use_last = 1'b1; vec[2].n = 4; vec[2].exp_n = 4;
        vec[2].data = {8'd10, 8'd50, 8'd30, 8'd20, {20{8'd0}}};
        vec[2].exp  = {e(50, 1, 0), e(30, 2, 0), e(20, 3, 0), e(10, 0, 0), e(0, 0, 0), e(0, 0, 0)};

        #1 Reset_n = 1'b0;
        #10 check_all_zero("reset");
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int v = 0; v < 3; v++) begin
            load_vec(v);
            run_frame(vec[v].mode, vec[v].mode ? 255 : 0, vec[v].use_last, 0, 100, 1'b0);
        end

        // Backpressure 1,0,0,1 with input gaps must give the same winners
        load_vec(0);
        run_frame(1'b0, 0, 1'b0, 40, -1, 1'b0);

        // Reset after the 10th input discards the frame
        load_vec(0);
        @(negedge Clk);
        Start = 1'b1;
        Mode  = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        for (int j = 0; j < 10; j++) begin
            InValid = 1'b1;
            InValue = stim[j];
            @(negedge Clk);
        end
        InValid = 1'b0;
        check("busy_before_reset", 32'(Busy), 32'd1);
        #2 Reset_n = 1'b0;
        #1 check_all_zero("midframe_reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        run_frame(1'b0, 0, 1'b0, 0, 100, 1'b0);

`ifdef SELECT_TOPK_THRESHOLD_EN
        load_vec(0);
        exp_q = exp_q[0:2];
        run_frame(1'b0, 220, 1'b0, 0, 100, 1'b0);
        exp_q.delete();
        run_frame(1'b0, 250, 1'b0, 0, 100, 1'b0);
`endif

        // Random frames against the reference model; Start/Mode are toggled while busy
        for (int f = 0; f < 40; f++) begin
            bit          mode, use_last;
            int          len;
            int unsigned thr;
            mode     = 1'($urandom);
            use_last = 1'($urandom);
            len      = use_last ? int'($urandom_range(1, N)) : int'(N);
`ifdef SELECT_TOPK_THRESHOLD_EN
            thr = $urandom_range(0, 255);
`else
            thr = mode ? 255 : 0;
`endif
            stim.delete();
            for (int j = 0; j < len; j++) begin
                stim.push_back((f % 2 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom));
            end
            build_model(mode, thr);
            run_frame(mode, thr, use_last, 30, 60, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
